// File: rtl/d16_bus_pkg.sv
// Shared types and constants for the 16-bit data bus blocks.
// Used by mem_arbiter and its mem_arb_pick helper.
package d16_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    localparam logic ARB_M_CORE   = 1'b0;
    localparam logic ARB_M_LOADER = 1'b1;

    // One-hot master vector for a master index
    function automatic logic [1:0] arb_onehot(input logic idx);
        logic [1:0] vec;
        if (idx == ARB_M_LOADER) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the two-master memory arbiter.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise the core always wins.
module mem_arb_pick
    import d16_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel
);

`ifdef MEM_ARB_RR_EN
    // On a tie the master that did not win the previous grant goes next
    always_comb begin
        sel = ARB_M_CORE;
        case (req)
            2'b01:   sel = ARB_M_CORE;
            2'b10:   sel = ARB_M_LOADER;
            2'b11:   sel = ~last;
            default: sel = ARB_M_CORE;
        endcase
    end
`else
    logic unused_last_s;
    assign unused_last_s = last;

    // Fixed priority: the core wins every tie
    always_comb begin
        sel = ARB_M_CORE;
        case (req)
            2'b01:   sel = ARB_M_CORE;
            2'b10:   sel = ARB_M_LOADER;
            2'b11:   sel = ARB_M_CORE;
            default: sel = ARB_M_CORE;
        endcase
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single data memory port, with a wait-timeout guard.
// Define MEM_ARB_RR_EN for round-robin tie breaking (default: fixed priority, core first).
module mem_arbiter
    import d16_bus_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_byte_en,
    input  logic              m0_byte_sel,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_byte_en,
    input  logic              m1_byte_sel,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_byte_en,
    output logic              mem_byte_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_wait
);

    localparam int              CNT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    arb_state_t        state_r, state_nxt_s;
    logic [1:0]        gnt_r, gnt_nxt_s;
    logic [1:0]        done_r, done_nxt_s;
    logic [1:0]        err_r, err_nxt_s;
    logic              err_flag_r, err_flag_nxt_s;
    logic              owner_r, owner_nxt_s;
    logic [CNT_W-1:0]  wait_cnt_r, wait_cnt_nxt_s;

    logic              mem_en_r, mem_en_nxt_s;
    logic              mem_we_r, mem_we_nxt_s;
    logic              mem_byte_en_r, mem_byte_en_nxt_s;
    logic              mem_byte_sel_r, mem_byte_sel_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic [DATA_W-1:0] rdata0_r, rdata0_nxt_s;
    logic [DATA_W-1:0] rdata1_r, rdata1_nxt_s;

    logic [1:0]        req_s;
    logic              sel_s;
    logic              last_s;
    logic              cmd_we_s;
    logic              cmd_byte_en_s;
    logic              cmd_byte_sel_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic [DATA_W-1:0] cmd_wdata_s;

    assign req_s = {m1_req, m0_req};

    mem_arb_pick u_pick (
        .req  (req_s),
        .last (last_s),
        .sel  (sel_s)
    );

`ifdef MEM_ARB_RR_EN
    logic last_r;

    // Most recent winner; reset value makes the core win the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if ((state_r == ARB_IDLE) && (req_s != 2'b00)) begin
            last_r <= sel_s;
        end else begin
            last_r <= last_r;
        end
    end

    assign last_s = last_r;
`else
    assign last_s = 1'b1;
`endif

    // Command of the selected master, captured only at grant
    always_comb begin
        if (sel_s == ARB_M_LOADER) begin
            cmd_we_s       = m1_we;
            cmd_byte_en_s  = m1_byte_en;
            cmd_byte_sel_s = m1_byte_sel;
            cmd_addr_s     = m1_addr;
            cmd_wdata_s    = m1_wdata;
        end else begin
            cmd_we_s       = m0_we;
            cmd_byte_en_s  = m0_byte_en;
            cmd_byte_sel_s = m0_byte_sel;
            cmd_addr_s     = m0_addr;
            cmd_wdata_s    = m0_wdata;
        end
    end

    // Next-state and next-output logic; everything holds unless an event changes it
    always_comb begin
        state_nxt_s        = state_r;
        gnt_nxt_s          = gnt_r;
        done_nxt_s         = 2'b00;
        err_nxt_s          = 2'b00;
        err_flag_nxt_s     = err_flag_r;
        owner_nxt_s        = owner_r;
        wait_cnt_nxt_s     = wait_cnt_r;
        mem_en_nxt_s       = mem_en_r;
        mem_we_nxt_s       = mem_we_r;
        mem_byte_en_nxt_s  = mem_byte_en_r;
        mem_byte_sel_nxt_s = mem_byte_sel_r;
        mem_addr_nxt_s     = mem_addr_r;
        mem_wdata_nxt_s    = mem_wdata_r;
        rdata0_nxt_s       = rdata0_r;
        rdata1_nxt_s       = rdata1_r;

        case (state_r)
            ARB_IDLE: begin
                if (req_s != 2'b00) begin
                    owner_nxt_s        = sel_s;
                    gnt_nxt_s          = arb_onehot(sel_s);
                    mem_en_nxt_s       = 1'b1;
                    mem_we_nxt_s       = cmd_we_s;
                    mem_byte_en_nxt_s  = cmd_byte_en_s;
                    mem_byte_sel_nxt_s = cmd_byte_sel_s;
                    mem_addr_nxt_s     = cmd_addr_s;
                    mem_wdata_nxt_s    = cmd_wdata_s;
                    wait_cnt_nxt_s     = {CNT_W{1'b0}};
                    err_flag_nxt_s     = 1'b0;
                    state_nxt_s        = ARB_ACCESS;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end

            ARB_ACCESS: begin
                if (!mem_wait) begin
                    if (owner_r == ARB_M_LOADER) begin
                        rdata1_nxt_s = mem_rdata;
                    end else begin
                        rdata0_nxt_s = mem_rdata;
                    end
                    mem_en_nxt_s = 1'b0;
                    state_nxt_s  = ARB_RESP;
                end else if (wait_cnt_r == WAIT_LIM) begin
                    // Memory hung: abort and report an error completion
                    mem_en_nxt_s   = 1'b0;
                    err_flag_nxt_s = 1'b1;
                    state_nxt_s    = ARB_RESP;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + CNT_W'(1);
                end
            end

            ARB_RESP: begin
                done_nxt_s     = arb_onehot(owner_r);
                if (err_flag_r) begin
                    err_nxt_s = arb_onehot(owner_r);
                end else begin
                    err_nxt_s = 2'b00;
                end
                gnt_nxt_s      = 2'b00;
                err_flag_nxt_s = 1'b0;
                state_nxt_s    = ARB_IDLE;
            end

            default: begin
                gnt_nxt_s    = 2'b00;
                mem_en_nxt_s = 1'b0;
                state_nxt_s  = ARB_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything, dropping any access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ARB_IDLE;
            gnt_r          <= 2'b00;
            done_r         <= 2'b00;
            err_r          <= 2'b00;
            err_flag_r     <= 1'b0;
            owner_r        <= ARB_M_CORE;
            wait_cnt_r     <= {CNT_W{1'b0}};
            mem_en_r       <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_byte_en_r  <= 1'b0;
            mem_byte_sel_r <= 1'b0;
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_wdata_r    <= {DATA_W{1'b0}};
            rdata0_r       <= {DATA_W{1'b0}};
            rdata1_r       <= {DATA_W{1'b0}};
        end else begin
            state_r        <= state_nxt_s;
            gnt_r          <= gnt_nxt_s;
            done_r         <= done_nxt_s;
            err_r          <= err_nxt_s;
            err_flag_r     <= err_flag_nxt_s;
            owner_r        <= owner_nxt_s;
            wait_cnt_r     <= wait_cnt_nxt_s;
            mem_en_r       <= mem_en_nxt_s;
            mem_we_r       <= mem_we_nxt_s;
            mem_byte_en_r  <= mem_byte_en_nxt_s;
            mem_byte_sel_r <= mem_byte_sel_nxt_s;
            mem_addr_r     <= mem_addr_nxt_s;
            mem_wdata_r    <= mem_wdata_nxt_s;
            rdata0_r       <= rdata0_nxt_s;
            rdata1_r       <= rdata1_nxt_s;
        end
    end

    assign m0_gnt       = gnt_r[0];
    assign m1_gnt       = gnt_r[1];
    assign m0_done      = done_r[0];
    assign m1_done      = done_r[1];
    assign m0_err       = err_r[0];
    assign m1_err       = err_r[1];
    assign m0_rdata     = rdata0_r;
    assign m1_rdata     = rdata1_r;
    assign mem_en       = mem_en_r;
    assign mem_we       = mem_we_r;
    assign mem_byte_en  = mem_byte_en_r;
    assign mem_byte_sel = mem_byte_sel_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int WM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [1:0]    req_v = 2'b00;
    logic [1:0]    we_v = 2'b00;
    logic [1:0]    ben_v = 2'b00;
    logic [1:0]    bsel_v = 2'b00;
    logic [AW-1:0] addr_v [2];
    logic [DW-1:0] wdata_v [2];
    logic [DW-1:0] mem_rdata = 16'h0000;
    logic          mem_wait = 1'b0;

    logic m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic mem_en, mem_we, mem_byte_en, mem_byte_sel;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0] gnt_v, done_v, err_v;

    assign gnt_v  = {m1_gnt, m0_gnt};
    assign done_v = {m1_done, m0_done};
    assign err_v  = {m1_err, m0_err};

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_MAX(WM)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req_v[0]), .m0_we(we_v[0]), .m0_byte_en(ben_v[0]), .m0_byte_sel(bsel_v[0]),
        .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(req_v[1]), .m1_we(we_v[1]), .m1_byte_en(ben_v[1]), .m1_byte_sel(bsel_v[1]),
        .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_byte_en(mem_byte_en), .mem_byte_sel(mem_byte_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_wait(mem_wait)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int            mdl_owner = -1;   // master currently holding the port, -1 when free
    int            mdl_waits = 0;    // wait cycles consumed by the current access
    bit            mdl_finishing = 1'b0;
    bit            mdl_fail = 1'b0;
    int            mdl_last = 1;
    int            mdl_w;
    logic [1:0]    e_gnt = 2'b00, e_done = 2'b00, e_err = 2'b00;
    logic [DW-1:0] e_rdata [2];
    logic          e_mem_en = 1'b0, e_we = 1'b0, e_ben = 1'b0, e_bsel = 1'b0;
    logic [AW-1:0] e_addr = 16'h0000;
    logic [DW-1:0] e_wdata = 16'h0000;

    always @(posedge clk) begin
        if (!rst_n) begin
            mdl_owner = -1; mdl_waits = 0; mdl_finishing = 1'b0; mdl_fail = 1'b0; mdl_last = 1;
            e_gnt = 2'b00; e_done = 2'b00; e_err = 2'b00;
            e_rdata[0] = 16'h0000; e_rdata[1] = 16'h0000;
            e_mem_en = 1'b0; e_we = 1'b0; e_ben = 1'b0; e_bsel = 1'b0;
            e_addr = 16'h0000; e_wdata = 16'h0000;
        end else begin
            e_done = 2'b00;
            e_err  = 2'b00;
            if (mdl_finishing) begin
                e_done[mdl_owner] = 1'b1;
                e_err[mdl_owner]  = mdl_fail;
                e_gnt = 2'b00;
                mdl_owner = -1;
                mdl_finishing = 1'b0;
            end else if (mdl_owner >= 0) begin
                if (!mem_wait) begin
                    e_rdata[mdl_owner] = mem_rdata;
                    e_mem_en = 1'b0; mdl_finishing = 1'b1; mdl_fail = 1'b0;
                end else if (mdl_waits == WM) begin
                    e_mem_en = 1'b0; mdl_finishing = 1'b1; mdl_fail = 1'b1;
                end else begin
                    mdl_waits++;
                end
            end else if (req_v != 2'b00) begin
                if (req_v == 2'b11) begin
`ifdef MEM_ARB_RR_EN
                    mdl_w = (mdl_last == 1) ? 0 : 1;
`else
                    mdl_w = 0;
`endif
                end else begin
                    mdl_w = req_v[1] ? 1 : 0;
                end
                mdl_last = mdl_w;
                mdl_owner = mdl_w;
                mdl_waits = 0;
                e_gnt = 2'b00;
                e_gnt[mdl_w] = 1'b1;
                e_mem_en = 1'b1;
                e_we = we_v[mdl_w]; e_ben = ben_v[mdl_w]; e_bsel = bsel_v[mdl_w];
                e_addr = addr_v[mdl_w]; e_wdata = wdata_v[mdl_w];
            end
        end
        #1;
        chk("gnt", gnt_v, e_gnt);
        chk("one_gnt", ($countones(gnt_v) <= 1), 1);
        chk("done", done_v, e_done);
        chk("err", err_v, e_err);
        chk("rdata0", m0_rdata, e_rdata[0]);
        chk("rdata1", m1_rdata, e_rdata[1]);
        chk("mem_en", mem_en, e_mem_en);
        if (e_mem_en) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_byte_en", mem_byte_en, e_ben);
            chk("mem_byte_sel", mem_byte_sel, e_bsel);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
        end
    end

    // ---------------- stimulus with hand-computed expectations ----------------
    logic [1:0] tie_exp [3];
    int         stuck = 0;

    initial begin
        addr_v[0] = 16'h0000; addr_v[1] = 16'h0000;
        wdata_v[0] = 16'h0000; wdata_v[1] = 16'h0000;
`ifdef MEM_ARB_RR_EN
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01;
`else
        tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01;
`endif
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt_v, 2'b00);
        chk("rst_mem_en", mem_en, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read: done two cycles after the request edge
        addr_v[0] = 16'h0010; we_v[0] = 1'b0; req_v[0] = 1'b1;
        mem_rdata = 16'hBEEF; mem_wait = 1'b0;
        @(negedge clk);
        chk("t1_gnt", gnt_v, 2'b01);
        chk("t1_mem_en", mem_en, 1'b1);
        chk("t1_addr", mem_addr, 16'h0010);
        @(negedge clk);
        chk("t1_not_yet", done_v, 2'b00);
        mem_rdata = 16'h0000;
        @(negedge clk);
        chk("t1_done", done_v, 2'b01);
        chk("t1_rdata", m0_rdata, 16'hBEEF);
        chk("t1_err", err_v, 2'b00);
        req_v[0] = 1'b0;
        @(negedge clk);
        chk("t1_pulse", done_v, 2'b00);

        // Write with three wait states; command must stay frozen
        addr_v[1] = 16'h0020; wdata_v[1] = 16'h1234; we_v[1] = 1'b1; req_v[1] = 1'b1;
        mem_wait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_gnt", gnt_v, 2'b10);
            chk("t2_en", mem_en, 1'b1);
            chk("t2_we", mem_we, 1'b1);
            chk("t2_wdata", mem_wdata, 16'h1234);
            chk("t2_addr", mem_addr, 16'h0020);
            chk("t2_not_yet", done_v, 2'b00);
            addr_v[1] = 16'($urandom); wdata_v[1] = 16'($urandom); we_v[1] = 1'b0;
            if (i == 3) mem_wait = 1'b0;
        end
        @(negedge clk);
        chk("t2_not_yet2", done_v, 2'b00);
        @(negedge clk);
        chk("t2_done", done_v, 2'b10);
        chk("t2_err", err_v, 2'b00);
        req_v[1] = 1'b0;
        @(negedge clk);

        // Tie with both requests held
        we_v = 2'b00; req_v = 2'b11;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) chk("t3_first_gnt", gnt_v, 2'b01);
            if (i % 3 == 2) chk("t3_order", done_v, tie_exp[i / 3]);
        end
        req_v = 2'b00;
        @(negedge clk);

        // Timeout with mem_wait stuck high
        addr_v[0] = 16'h0040; req_v[0] = 1'b1; mem_wait = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("t4_en", mem_en, (i <= 4) ? 1'b1 : 1'b0);
            chk("t4_done", done_v, (i == 6) ? 2'b01 : 2'b00);
            chk("t4_err", err_v, (i == 6) ? 2'b01 : 2'b00);
        end
        req_v[0] = 1'b0; mem_wait = 1'b0;
        @(negedge clk);
        req_v[0] = 1'b1; mem_rdata = 16'h5A5A;
        repeat (3) @(negedge clk);
        chk("t4_recover_done", done_v, 2'b01);
        chk("t4_recover_err", err_v, 2'b00);
        chk("t4_recover_rdata", m0_rdata, 16'h5A5A);
        req_v[0] = 1'b0;
        @(negedge clk);

        // Reset in the middle of an access
        addr_v[1] = 16'h00F0; wdata_v[1] = 16'hCAFE; we_v[1] = 1'b1; ben_v[1] = 1'b1; bsel_v[1] = 1'b1;
        req_v[1] = 1'b1; mem_wait = 1'b1;
        @(negedge clk);
        chk("t5_gnt", gnt_v, 2'b10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_gnt0", gnt_v, 2'b00);
        chk("t5_done0", done_v, 2'b00);
        chk("t5_err0", err_v, 2'b00);
        chk("t5_rdata0", m0_rdata, 16'h0000);
        chk("t5_rdata1", m1_rdata, 16'h0000);
        chk("t5_mem", {mem_en, mem_we, mem_byte_en, mem_byte_sel}, 4'h0);
        chk("t5_addr", mem_addr, 16'h0000);
        chk("t5_wdata", mem_wdata, 16'h0000);
        rst_n = 1'b1; mem_wait = 1'b0;
        @(negedge clk);
        chk("t5_regrant", gnt_v, 2'b10);
        repeat (2) @(negedge clk);
        chk("t5_done", done_v, 2'b10);
        req_v[1] = 1'b0; ben_v = 2'b00; bsel_v = 2'b00;
        @(negedge clk);

        // Randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (!req_v[m]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_v[m] = 1'b1;
                        we_v[m] = 1'($urandom); ben_v[m] = 1'($urandom); bsel_v[m] = 1'($urandom);
                        addr_v[m] = 16'($urandom); wdata_v[m] = 16'($urandom);
                    end
                end else if (done_v[m]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        addr_v[m] = 16'($urandom); wdata_v[m] = 16'($urandom);
                    end else begin
                        req_v[m] = 1'b0;
                    end
                end else if (gnt_v[m]) begin
                    we_v[m] = 1'($urandom); addr_v[m] = 16'($urandom); wdata_v[m] = 16'($urandom);
                end
            end
            mem_rdata = 16'($urandom);
            if (stuck > 0) begin
                mem_wait = 1'b1;
                stuck--;
            end else begin
                if ($urandom_range(0, 40) == 0) stuck = $urandom_range(3, 7);
                mem_wait = ($urandom_range(0, 2) == 0);
            end
            rst_n = ($urandom_range(0, 150) != 0);
        end
        rst_n = 1'b1;
        req_v = 2'b00;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
